// File: rtl/branch_redirect.sv
// branch_redirect: resolves EX-stage control transfers and holds a fetch redirect.
// Define BRANCH_STATS_EN to build the saturating transfer/taken counters.
module branch_redirect (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_npc_sel,
    input  logic [2:0]  ex_cmp_op,
    input  logic [63:0] ex_rs1,
    input  logic [63:0] ex_rs2,
    input  logic [63:0] ex_pc,
    input  logic [63:0] ex_target,
    input  logic        redirect_ready,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic [3:0]  br_taken,
    output logic        flush_if,
    output logic        flush_id,
    output logic        ex_stall,
    output logic        misalign_exc,
    output logic [63:0] misalign_pc,
    output logic [31:0] stat_xfer,
    output logic [31:0] stat_taken
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic taken;
    logic aligned;
    logic go_hold;
    logic bad_tgt;
    logic flush_q;

    assign ex_stall       = (state == HOLD);
    assign redirect_valid = (state == HOLD);
    assign accept         = ex_valid & ex_npc_sel & ~ex_stall;
    assign aligned        = (ex_target[1:0] == 2'b00);
    assign bad_tgt        = accept & taken & ~aligned;
    assign flush_if       = flush_q;
    assign flush_id       = flush_q;

    always_comb begin
        taken = 1'b0;
        unique case (ex_cmp_op)
            3'd0: taken = 1'b1;
            3'd1: taken = (ex_rs1 == ex_rs2);
            3'd2: taken = (ex_rs1 != ex_rs2);
            3'd3: taken = ($signed(ex_rs1) < $signed(ex_rs2));
            3'd4: taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'd5: taken = (ex_rs1 < ex_rs2);
            3'd6: taken = (ex_rs1 >= ex_rs2);
            3'd7: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        go_hold   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && taken && aligned) begin
                    state_nxt = HOLD;
                    go_hold   = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_ready) state_nxt = IDLE;
            end
        endcase
    end

    // flush_q marks only the entry edge, so it spans the first HOLD cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            redirect_pc  <= '0;
            br_taken     <= '0;
            flush_q      <= 1'b0;
            misalign_exc <= 1'b0;
            misalign_pc  <= '0;
        end else begin
            state        <= state_nxt;
            flush_q      <= go_hold;
            br_taken     <= accept ? {taken, ex_cmp_op} : 4'b0000;
            misalign_exc <= bad_tgt;
            if (go_hold) redirect_pc <= ex_target;
            if (bad_tgt) misalign_pc <= ex_pc;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_xfer  <= '0;
            stat_taken <= '0;
        end else if (accept) begin
            if (stat_xfer != '1) stat_xfer <= stat_xfer + 32'd1;
            if (taken && stat_taken != '1) stat_taken <= stat_taken + 32'd1;
        end
    end
`else
    assign stat_xfer  = '0;
    assign stat_taken = '0;
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// tb_branch_redirect: vector table, corner sequences and random run
// against a cycle-level reference model of branch_redirect.
module tb_branch_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_npc_sel;
    logic [2:0]  ex_cmp_op;
    logic [63:0] ex_rs1;
    logic [63:0] ex_rs2;
    logic [63:0] ex_pc;
    logic [63:0] ex_target;
    logic        redirect_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [3:0]  br_taken;
    logic        flush_if;
    logic        flush_id;
    logic        ex_stall;
    logic        misalign_exc;
    logic [63:0] misalign_pc;
    logic [31:0] stat_xfer;
    logic [31:0] stat_taken;

    always #5 clk = ~clk;

    branch_redirect dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_npc_sel     (ex_npc_sel),
        .ex_cmp_op      (ex_cmp_op),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .redirect_ready (redirect_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .br_taken       (br_taken),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .ex_stall       (ex_stall),
        .misalign_exc   (misalign_exc),
        .misalign_pc    (misalign_pc),
        .stat_xfer      (stat_xfer),
        .stat_taken     (stat_taken)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    bit              m_pend;
    int              m_age;
    logic [63:0]     m_rpc;
    logic [3:0]      m_bt;
    bit              m_mis;
    logic [63:0]     m_mpc;
    longint unsigned m_nx;
    longint unsigned m_nt;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  bt;
        bit          redir;
    } vec_t;

    vec_t tbl[10];

    function automatic bit ref_taken(input logic [2:0] op,
                                     input logic [63:0] a,
                                     input logic [63:0] b);
        longint sa = a;
        longint sb = b;
        longint unsigned ua = a;
        longint unsigned ub = b;
        case (op)
            3'd0: return 1;
            3'd1: return ua == ub;
            3'd2: return ua != ub;
            3'd3: return sa < sb;
            3'd4: return !(sa < sb);
            3'd5: return ua < ub;
            3'd6: return !(ua < ub);
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit acc;
        bit tk;
        acc = ex_valid && ex_npc_sel && !m_pend;
        tk  = acc && ref_taken(ex_cmp_op, ex_rs1, ex_rs2);
        if (rst) begin
            m_pend = 0; m_age = 0; m_rpc = 0; m_bt = 0;
            m_mis = 0; m_mpc = 0; m_nx = 0; m_nt = 0;
        end else begin
            m_bt  = acc ? {tk, ex_cmp_op} : 4'd0;
            m_mis = tk && (ex_target % 4 != 0);
            if (m_mis) m_mpc = ex_pc;
            if (acc && m_nx < 64'hFFFF_FFFF) m_nx++;
            if (tk && m_nt < 64'hFFFF_FFFF) m_nt++;
            if (m_pend) begin
                if (redirect_ready) m_pend = 0;
                m_age++;
            end else if (tk && ex_target % 4 == 0) begin
                m_pend = 1;
                m_age  = 0;
                m_rpc  = ex_target;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] ex_x;
        logic [31:0] ex_t;
`ifdef BRANCH_STATS_EN
        ex_x = 32'(m_nx);
        ex_t = 32'(m_nt);
`else
        ex_x = 0;
        ex_t = 0;
`endif
        chk("redirect_valid", 64'(redirect_valid), 64'(m_pend));
        chk("ex_stall", 64'(ex_stall), 64'(m_pend));
        chk("redirect_pc", redirect_pc, m_pend ? m_rpc : redirect_pc === m_rpc ? m_rpc : m_rpc);
        chk("br_taken", 64'(br_taken), 64'(m_bt));
        chk("flush_if", 64'(flush_if), 64'(m_pend && m_age == 0));
        chk("flush_id", 64'(flush_id), 64'(m_pend && m_age == 0));
        chk("misalign_exc", 64'(misalign_exc), 64'(m_mis));
        chk("misalign_pc", misalign_pc, m_mpc);
        chk("stat_xfer", 64'(stat_xfer), 64'(ex_x));
        chk("stat_taken", 64'(stat_taken), 64'(ex_t));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic present(input bit v, input logic [2:0] op,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] tgt, input logic [63:0] pc);
        ex_valid   = v;
        ex_npc_sel = v;
        ex_cmp_op  = op;
        ex_rs1     = a;
        ex_rs2     = b;
        ex_target  = tgt;
        ex_pc      = pc;
    endtask

    task automatic idle_in();
        present(0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    endtask

    initial begin
        logic [63:0] neg1;
        int hi_cnt;
        neg1 = '1;

        tbl[0] = '{3'd1, 64'd5, 64'd5, 4'b1001, 1};
        tbl[1] = '{3'd1, 64'd5, 64'd6, 4'b0001, 0};
        tbl[2] = '{3'd2, 64'd5, 64'd6, 4'b1010, 1};
        tbl[3] = '{3'd3, neg1,  64'd1, 4'b1011, 1};
        tbl[4] = '{3'd5, neg1,  64'd1, 4'b0101, 0};
        tbl[5] = '{3'd4, neg1,  64'd1, 4'b0100, 0};
        tbl[6] = '{3'd6, neg1,  64'd1, 4'b1110, 1};
        tbl[7] = '{3'd7, 64'd3, 64'd3, 4'b0111, 0};
        tbl[8] = '{3'd0, 64'd0, 64'd9, 4'b1000, 1};
        tbl[9] = '{3'd3, 64'd1, neg1,  4'b0011, 0};

        rst = 1'b1;
        redirect_ready = 1'b1;
        idle_in();
        step();
        step();
        chk("reset_br_taken", 64'(br_taken), 64'd0);
        chk("reset_redirect_pc", redirect_pc, 64'd0);
        rst = 1'b0;

        // compare-type table, one transfer each from IDLE
        for (int i = 0; i < 10; i++) begin
            present(1, tbl[i].op, tbl[i].a, tbl[i].b, 64'h1000, 64'h100);
            step();
            chk($sformatf("tbl%0d_br_taken", i), 64'(br_taken), 64'(tbl[i].bt));
            chk($sformatf("tbl%0d_redirect", i), 64'(redirect_valid), 64'(tbl[i].redir));
            if (tbl[i].redir) begin
                chk($sformatf("tbl%0d_pc", i), redirect_pc, 64'h1000);
                chk($sformatf("tbl%0d_flush", i), 64'(flush_if & flush_id), 64'd1);
            end
            idle_in();
            step();
        end

        // long HOLD, new transfer offered on the exit cycle is ignored
        redirect_ready = 1'b0;
        present(1, 3'd0, 64'd0, 64'd0, 64'h2000, 64'h300);
        hi_cnt = 0;
        step();
        idle_in();
        for (int c = 0; c < 4; c++) begin
            if (redirect_valid && ex_stall) hi_cnt++;
            chk($sformatf("hold%0d_flush", c), 64'(flush_if), 64'(c == 0));
            if (c == 3) begin
                redirect_ready = 1'b1;
                present(1, 3'd1, 64'd7, 64'd7, 64'h3000, 64'h310);
            end
            step();
        end
        chk("hold_cycles", 64'(hi_cnt), 64'd4);
        chk("hold_exit", 64'(redirect_valid), 64'd0);
        chk("hold_exit_bt", 64'(br_taken), 64'd0);
        idle_in();
        step();

        // misaligned target
        present(1, 3'd0, 64'd0, 64'd0, 64'h2002, 64'h400);
        step();
        chk("mis_exc", 64'(misalign_exc), 64'd1);
        chk("mis_pc", misalign_pc, 64'h400);
        chk("mis_noredir", 64'(redirect_valid), 64'd0);
        idle_in();
        step();
        chk("mis_pulse_end", 64'(misalign_exc), 64'd0);

        // reset while in HOLD
        redirect_ready = 1'b0;
        present(1, 3'd0, 64'd0, 64'd0, 64'h5000, 64'h500);
        step();
        idle_in();
        rst = 1'b1;
        step();
        chk("rst_hold_valid", 64'(redirect_valid), 64'd0);
        chk("rst_hold_stall", 64'(ex_stall), 64'd0);
        chk("rst_hold_flush", 64'(flush_if | flush_id), 64'd0);
        chk("rst_hold_pc", redirect_pc, 64'd0);
        rst = 1'b0;
        redirect_ready = 1'b1;

        // 10 transfers, 4 taken
        for (int k = 0; k < 10; k++) begin
            if (k % 3 == 0) present(1, 3'd0, 64'd0, 64'd0, 64'h6000, 64'h600);
            else            present(1, 3'd7, 64'd0, 64'd0, 64'h6000, 64'h600);
            step();
            idle_in();
            step();
        end
`ifdef BRANCH_STATS_EN
        chk("stat_xfer_10", 64'(stat_xfer), 64'd10);
        chk("stat_taken_4", 64'(stat_taken), 64'd4);
`else
        chk("stat_xfer_off", 64'(stat_xfer), 64'd0);
        chk("stat_taken_off", 64'(stat_taken), 64'd0);
`endif

        // randomized run
        for (int r = 0; r < 3000; r++) begin
            logic [63:0] pool [4];
            logic [63:0] tgt;
            pool[0] = 64'd0;
            pool[1] = 64'd1;
            pool[2] = neg1;
            pool[3] = 64'h8000_0000_0000_0000;
            tgt = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            ex_valid       = ($urandom_range(0, 3) != 0);
            ex_npc_sel     = ($urandom_range(0, 2) != 0);
            ex_cmp_op      = 3'($urandom_range(0, 7));
            ex_rs1         = pool[$urandom_range(0, 3)];
            ex_rs2         = pool[$urandom_range(0, 3)];
            ex_target      = tgt;
            ex_pc          = {$urandom, $urandom};
            redirect_ready = ($urandom_range(0, 2) != 0);
            rst            = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect.md
BRANCH_REDIRECT -- requirements
Module: branch_redirect

Interface
REQ-001 The block SHALL have these ports: clk  in  1  system clock, rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 ex_valid  in  1  EX stage holds a valid instruction.
REQ-004 ex_npc_sel  in  1  EX instruction is a control transfer (jump or branch).
REQ-005 ex_cmp_op  in  3  compare type: 0 unconditional jump, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 reserved.
REQ-006 ex_rs1, ex_rs2  in  64  each; branch operands.
REQ-007 ex_pc, ex_target  in  64  each; instruction PC and computed target (ALU result).
REQ-008 redirect_ready  in  1  fetch side accepts redirect_pc this cycle.
REQ-009 redirect_valid, redirect_pc  out  1, 64  pending PC redirect to fetch.
REQ-010 br_taken  out  4  registered {taken, ex_cmp_op}; consumed by the PC select logic.
REQ-011 flush_if, flush_id  out  1 each  one-cycle squash of the IF and ID stages.
REQ-012 ex_stall  out  1  hold EX; high while a redirect is pending.
REQ-013 misalign_exc, misalign_pc  out  1, 64  target not 4-byte aligned; pulse plus faulting PC.
REQ-014 stat_xfer, stat_taken  out  32 each  statistics counters (see Configuration).

Function
REQ-015 A transfer SHALL be accepted when ex_valid & ex_npc_sel & !ex_stall; all other cycles SHALL ignore the ex_* inputs.
REQ-016 Taken SHALL be: op 0 always; 1 rs1==rs2; 2 rs1!=rs2; 3 signed rs1<rs2; 4 signed rs1>=rs2; 5 unsigned rs1<rs2; 6 unsigned rs1>=rs2; 7 never.
REQ-017 br_taken SHALL register {taken, ex_cmp_op} on every accepted transfer and SHALL be 0 in the cycle after any non-accepting cycle.
REQ-018 The FSM SHALL have states IDLE and HOLD; reset state IDLE.
REQ-019 IDLE -> HOLD on an accepted taken transfer with ex_target[1:0]==0; redirect_pc<=ex_target.
REQ-020 redirect_valid SHALL equal (state==HOLD); latency from accepting edge to redirect_valid=1 SHALL be exactly 1 cycle.
REQ-021 HOLD -> IDLE on any edge with redirect_ready=1; redirect_pc SHALL stay stable while in HOLD.
REQ-022 ex_stall SHALL equal (state==HOLD), combinationally from state.
REQ-023 flush_if and flush_id SHALL both pulse high only in the first HOLD cycle, even when HOLD lasts several cycles.
REQ-024 An accepted taken transfer with ex_target[1:0]!=0 SHALL NOT redirect; misalign_exc SHALL pulse 1 cycle later with misalign_pc=ex_pc.
REQ-025 A not-taken transfer SHALL produce no redirect, flush, or stall.
REQ-026 A transfer presented in the same cycle as the HOLD->IDLE exit SHALL be ignored, since ex_stall=1; the pipeline re-presents it.

Reset
REQ-027 While rst=1 at an edge, the FSM SHALL go to IDLE and the block SHALL drive redirect_valid, redirect_pc, br_taken, flush_*, misalign_exc, misalign_pc and stat_* to 0.
REQ-028 Reset asserted while in HOLD SHALL drop the pending redirect without a flush pulse.

Configuration
REQ-029 With BRANCH_STATS_EN defined, stat_xfer SHALL count accepted transfers and stat_taken SHALL count taken ones; both counters SHALL saturate at 0xFFFFFFFF.
REQ-030 Without BRANCH_STATS_EN, stat_xfer and stat_taken SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-031 BEQ, rs1=rs2=5, target 0x1000 -> next cycle: redirect_valid=1, redirect_pc=0x1000, br_taken=4'b1001, flush_if=flush_id=1.
REQ-032 BLT vs BLTU with rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1 -> BLT taken (br_taken=4'b1011); BLTU not taken (br_taken=4'b0101, no redirect).
REQ-033 Jump to 0x2000 with redirect_ready=0 for 3 cycles -> redirect_valid and ex_stall high for 4 cycles; flush only in the first; IDLE after the ready edge.
REQ-034 Jump to 0x2002 with ex_pc=0x400 -> no redirect; misalign_exc=1 for one cycle with misalign_pc=0x400.
REQ-035 rst=1 during HOLD -> next cycle all outputs 0 and state IDLE.
REQ-036 With BRANCH_STATS_EN defined: 10 transfers, 4 of them taken -> stat_xfer=10, stat_taken=4; without the macro both stay 0.
